// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider, BPC quotient bits per clock.
// Unsigned or signed (truncating) division chosen per operation; divide-by-zero flagged.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    operand handshake (ready only in IDLE)
//   dividend_i [DW], divisor_i [VW], is_signed_i   operands, sampled on accept
//   out_valid_o / out_ready_i  result handshake
//   quotient_o [DW], remainder_o [DW], div_zero_o  registered results
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready_o high
// CALC  | BPC shift-subtract steps per cycle, counter running down
// FIX   | apply signs, write result registers, raise out_valid_o
// DONE  | hold result until consumed (entered with out_valid_o low on /0)
module seq_divider #(
   parameter int DW  = 32,
   parameter int VW  = 16,
   parameter int BPC = 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] dividend_i,
   input  logic [VW-1:0] divisor_i,
   input  logic          is_signed_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] quotient_o,
   output logic [DW-1:0] remainder_o,
   output logic          div_zero_o
);

   localparam int PW  = DW + VW + 1;
   localparam int NIT = DW / BPC;
   localparam int CW  = $clog2(NIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] work_q, work_d;     // dividend magnitude shifting out, quotient shifting in
   logic [PW-1:0] prem_q, prem_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_quo_q, neg_quo_d;
   logic          neg_rem_q, neg_rem_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [DW-1:0] rem_q, rem_d;
   logic          dz_q, dz_d;

   logic [PW-1:0] step_p;
   logic [DW-1:0] step_w;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         work_q      <= '0;
         prem_q      <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         out_valid_q <= 1'b0;
         quo_q       <= '0;
         rem_q       <= '0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         prem_q      <= prem_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         out_valid_q <= out_valid_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         dz_q        <= dz_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      prem_d      = prem_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      out_valid_d = out_valid_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      dz_d        = dz_q;

      step_p = prem_q;
      step_w = work_q;
      for (int i = 0; i < BPC; i++) begin
         step_p = {step_p[PW-2:0], step_w[DW-1]};
         step_w = {step_w[DW-2:0], 1'b0};
         if (step_p >= PW'(dvs_q)) begin
            step_p    = step_p - PW'(dvs_q);
            step_w[0] = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               if (divisor_i == '0) begin
                  // results land now; out_valid follows one edge later from DONE
                  quo_d   = '1;
                  rem_d   = dividend_i;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  work_d    = (is_signed_i && dividend_i[DW-1]) ? -dividend_i : dividend_i;
                  dvs_d     = (is_signed_i && divisor_i[VW-1]) ? -divisor_i : divisor_i;
                  prem_d    = '0;
                  cnt_d     = CW'(NIT);
                  neg_quo_d = is_signed_i && (dividend_i[DW-1] ^ divisor_i[VW-1]);
                  neg_rem_d = is_signed_i && dividend_i[DW-1];
                  state_d   = S_CALC;
               end
            end
         end
         S_CALC: begin
            prem_d = step_p;
            work_d = step_w;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            // most-negative / -1 wraps naturally through the negation
            quo_d       = neg_quo_q ? -work_q : work_q;
            rem_d       = neg_rem_q ? -prem_q[DW-1:0] : prem_q[DW-1:0];
            dz_d        = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = out_valid_q;
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign div_zero_o  = dz_q;

endmodule
